// File: rtl/pll_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : pll_seq_pkg
// Brief    : Shared types and register map for the PLL reset sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pll_seq_pkg;

  // Sequencer states; the encoding is visible in STATUS[7:4].
  typedef enum logic [3:0] {
    ST_ASSERT    = 4'd0,
    ST_WAIT_LOCK = 4'd1,
    ST_STABLE    = 4'd2,
    ST_RELEASE   = 4'd3,
    ST_RUN       = 4'd4
  } state_e;

  // Register addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;

  // STATUS bit positions
  localparam int STAT_RUNNING   = 0;
  localparam int STAT_LOCK      = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_LOSS_LSB  = 8;

  // CONTROL bit positions
  localparam int CTRL_PLL_RESET   = 0;
  localparam int CTRL_HOLD        = 1;
  localparam int CTRL_CLEAR_STATS = 2;

  // Largest of four values; sizes the shared cycle counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module   : sync_2ff
// Brief    : Two-flop synchronizer; both stages clear to 0 on areset_n.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic areset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pll_reset_sequencer
// Brief    : Owns the PLL areset/lock handshake and releases per-domain resets
//            in order once lock is stable. Avalon-MM STATUS/CONTROL registers.
// Options  : PLL_SEQ_WATCHDOG_EN - WAIT_LOCK timeout with sticky status bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 64,
  parameter int STAGE_GAP      = 8,
  parameter int NUM_DOMAINS    = 3,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic [2:0]             address,
  input  logic                   chipselect,
  input  logic                   read,
  input  logic                   write,
  input  logic [15:0]            writedata,
  output logic [15:0]            readdata,
  input  logic                   pll_locked,
  output logic                   pll_areset,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   resetrequest
);

  import pll_seq_pkg::*;

  // One counter serves every timed state; size it for the longest interval.
  localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_STABLE, STAGE_GAP, LOCK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
`ifdef PLL_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [7:0]             loss_q, loss_d;
  logic                   timeout_q, timeout_d;
  logic                   hold_q, hold_d;
  logic                   lock_s;
  logic                   loss_evt;

  logic                   wr_ctrl;
  logic                   sw_rst;
  logic                   clr_stats;
  logic [NUM_DOMAINS-1:0] dom_shift;
  logic                   unused_wdata;

  sync_2ff u_lock_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .d_i      (pll_locked),
    .q_o      (lock_s)
  );

  assign wr_ctrl      = chipselect && write && (address == ADDR_CONTROL);
  assign sw_rst       = wr_ctrl && writedata[CTRL_PLL_RESET];
  assign clr_stats    = wr_ctrl && writedata[CTRL_CLEAR_STATS];
  assign dom_shift    = (dom_q << 1) | NUM_DOMAINS'(1);
  assign unused_wdata = ^writedata[15:3];

  // State, counters and control/status registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      dom_q     <= '0;
      loss_q    <= '0;
      timeout_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dom_q     <= dom_d;
      loss_q    <= loss_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  // Sequencing: next state, domain releases, loss counting, software reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dom_d     = dom_q;
    loss_d    = loss_q;
    timeout_d = timeout_q;
    hold_d    = wr_ctrl ? writedata[CTRL_HOLD] : hold_q;
    loss_evt  = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        dom_d = '0;
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          // The cycle that ends the wait already counts as one locked cycle.
          state_d = ST_STABLE;
          cnt_d   = CNT_W'(1);
        end else begin
`ifdef PLL_SEQ_WATCHDOG_EN
          if (cnt_q == TMO_LAST) begin
            state_d   = ST_ASSERT;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STABLE_LAST) begin
          state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          dom_d   = NUM_DOMAINS'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
        end else if (!hold_q) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            dom_d = dom_shift;
            if (&dom_shift) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (!lock_s) loss_evt = 1'b1;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase

    if (loss_evt) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      dom_d   = '0;
    end

    // A software reset overrides a coincident lock loss and is not counted.
    if (loss_evt && !sw_rst && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;

    if (sw_rst) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      dom_d   = '0;
    end

    if (clr_stats) begin
      loss_d    = '0;
      timeout_d = 1'b0;
    end
  end

  assign pll_areset   = (state_q == ST_ASSERT);
  assign domain_rst_n = dom_q;
  assign resetrequest = ~&dom_q;

  // Zero-wait register read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        ADDR_STATUS: begin
          readdata[STAT_RUNNING]           = (state_q == ST_RUN);
          readdata[STAT_LOCK]              = lock_s;
          readdata[STAT_TIMEOUT]           = timeout_q;
          readdata[STAT_STATE_LSB +: 4]    = state_q;
          readdata[STAT_LOSS_LSB +: 8]     = loss_q;
        end
        ADDR_CONTROL: begin
          readdata[CTRL_HOLD] = hold_q;
        end
        default: readdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire
